// File: rtl/pifo_pkg.sv
// Shared helpers for the PIFO flow-control shim.
// Provides the data-width computation and the counter/pointer width
// helpers used to size occupancy counters and FIFO pointers.
package pifo_pkg;

    // Entry width: metadata sits above the rank field.
    function automatic int calc_dw(input int ptw, input int mtw);
        return ptw + mtw;
    endfunction

    // Width of a counter that must hold values 0..n (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a pointer that indexes 0..depth-1 (never narrower than 1 bit).
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pifo_flow_ctrl_chk.sv
// Run-time checks for the flow-control shim: no push/pop collision,
// no occupancy over/underflow, no write into a full output buffer.
// Ports: clock/reset plus the observed strobes and counters (inputs only).
module pifo_flow_ctrl_chk #(
    parameter int CAPACITY   = 64,
    parameter int OBUF_DEPTH = 4,
    parameter int CW         = 7,
    parameter int OCW        = 3
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic [CW-1:0]  i_count,
    input  logic           i_obuf_wr,
    input  logic           i_obuf_rd,
    input  logic [OCW-1:0] i_obuf_count
);

    // Sample the protocol invariants on every active edge outside reset.
    always @(posedge i_clk) begin
        if (i_arst_n) begin
            assert (!(i_push && i_pop))
                else $error("pifo_flow_ctrl: push and pop in same cycle");
            assert (!(i_push && (int'(i_count) >= CAPACITY)))
                else $error("pifo_flow_ctrl: push into full PIFO");
            assert (!(i_pop && (i_count == CW'(0))))
                else $error("pifo_flow_ctrl: pop from empty PIFO");
            assert (!(i_obuf_wr && !i_obuf_rd && (int'(i_obuf_count) >= OBUF_DEPTH)))
                else $error("pifo_flow_ctrl: write into full output buffer");
        end
    end

endmodule

// File: rtl/pifo_obuf.sv
// Output buffer: parameterised synchronous FIFO with occupancy output.
// Ports:
//   i_clk, i_arst_n     clock, asynchronous active-low reset
//   i_wr_en, i_wr_data  write strobe and data (ignored when full without a read)
//   i_rd_en             pop the head entry (ignored when empty)
//   o_valid, o_data     head entry (data forced to 0 when empty)
//   o_count             number of stored entries
module pifo_obuf
    import pifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic                      i_wr_en,
    input  logic [DW-1:0]             i_wr_data,
    input  logic                      i_rd_en,
    output logic                      o_valid,
    output logic [DW-1:0]             o_data,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_rd;
    logic          w_wr;

    // Qualify strobes: a full buffer still accepts a write when the head leaves.
    always_comb begin
        w_rd = i_rd_en && (r_count != CW'(0));
        w_wr = i_wr_en && ((r_count != CW'(DEPTH)) || w_rd);
    end

    // Head presentation; data is zeroed while empty so nothing stale leaks out.
    always_comb begin
        o_valid = (r_count != CW'(0));
        o_count = r_count;
        if (o_valid) begin
            o_data = r_mem[r_rd_ptr];
        end else begin
            o_data = '0;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pifo_flow_ctrl.sv
// Flow-control shim around a PIFO: turns an upstream valid/ready stream
// into single-cycle pushes, issues paced pops only when the output buffer
// has room for the result, and presents results on a valid/ready stream.
// Ports:
//   i_clk, i_arst_n            clock, asynchronous active-low reset
//   i_in_valid/o_in_ready      upstream handshake, i_in_data = {meta, rank}
//   o_push, o_push_data        push strobe/data to the PIFO (same cycle as accept)
//   o_pop, i_pop_data          pop strobe to the PIFO, result POP_LAT cycles later
//   o_out_valid/i_out_ready    downstream handshake, o_out_data = buffer head
//   o_count                    tracked PIFO occupancy
module pifo_flow_ctrl
    import pifo_pkg::*;
#(
    parameter  int PTW        = 8,
    parameter  int MTW        = 0,
    parameter  int CAPACITY   = 64,
    parameter  int POP_GAP    = 1,
    parameter  int POP_LAT    = 1,
    parameter  int OBUF_DEPTH = 4,
    localparam int DW         = calc_dw(PTW, MTW),
    localparam int CW         = cnt_w(CAPACITY)
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_push,
    output logic [DW-1:0] o_push_data,
    output logic          o_pop,
    input  logic [DW-1:0] i_pop_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic [CW-1:0] o_count
);

    localparam int GW  = cnt_w(POP_GAP);
    localparam int LW  = cnt_w(POP_LAT);
    localparam int OCW = cnt_w(OBUF_DEPTH);

    logic               r_live;      // low during and until the first edge after reset
    logic               r_rr_pop;    // 1: pop side has priority on the next conflict
    logic [CW-1:0]      r_count;
    logic [GW-1:0]      r_gap_cnt;
    logic [POP_LAT-1:0] r_lat_pipe;
    logic [LW-1:0]      w_inflight;
    logic [OCW-1:0]     w_obuf_count;
    logic               w_credit_ok;
    logic               w_pop_elig;
    logic               w_obuf_wr;
    logic               w_out_hs;

    // Count pops whose results have not yet reached the output buffer.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < POP_LAT; i++) begin
            w_inflight = w_inflight + LW'(r_lat_pipe[i]);
        end
    end

    // Pop eligibility, upstream ready and push/pop arbitration.
    // Buffered plus in-flight results are treated as reserved slots, so a pop
    // is only issued when its result is guaranteed a place to land.
    always_comb begin
        w_credit_ok = (int'(w_obuf_count) + int'(w_inflight)) < OBUF_DEPTH;
        w_pop_elig  = (r_count != CW'(0)) && (int'(r_gap_cnt) >= POP_GAP) && w_credit_ok;
        o_in_ready  = r_live && (int'(r_count) < CAPACITY) && !(w_pop_elig && r_rr_pop);
        o_push      = i_in_valid && o_in_ready;
        o_pop       = w_pop_elig && !o_push;
        o_count     = r_count;
        w_obuf_wr   = r_lat_pipe[POP_LAT-1];
        w_out_hs    = o_out_valid && i_out_ready;
        if (o_push) begin
            o_push_data = i_in_data;
        end else begin
            o_push_data = '0;
        end
    end

    // Occupancy, round-robin priority, pop pacing and the latency pipe.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_live     <= 1'b0;
            r_rr_pop   <= 1'b0;
            r_count    <= '0;
            r_gap_cnt  <= GW'(POP_GAP);
            r_lat_pipe <= '0;
        end else begin
            r_live <= 1'b1;
            if (o_push) begin
                if (int'(r_count) < CAPACITY) begin
                    r_count <= r_count + CW'(1);
                end
                r_rr_pop <= 1'b1;
            end else if (o_pop) begin
                if (r_count != CW'(0)) begin
                    r_count <= r_count - CW'(1);
                end
                r_rr_pop <= 1'b0;
            end
            if (o_pop) begin
                r_gap_cnt <= '0;
            end else if (int'(r_gap_cnt) < POP_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end
            r_lat_pipe[0] <= o_pop;
            for (int i = 1; i < POP_LAT; i++) begin
                r_lat_pipe[i] <= r_lat_pipe[i-1];
            end
        end
    end

    pifo_obuf #(
        .DEPTH (OBUF_DEPTH),
        .DW    (DW)
    ) u_obuf (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_wr_en   (w_obuf_wr),
        .i_wr_data (i_pop_data),
        .i_rd_en   (w_out_hs),
        .o_valid   (o_out_valid),
        .o_data    (o_out_data),
        .o_count   (w_obuf_count)
    );

    pifo_flow_ctrl_chk #(
        .CAPACITY   (CAPACITY),
        .OBUF_DEPTH (OBUF_DEPTH),
        .CW         (CW),
        .OCW        (OCW)
    ) u_chk (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_push       (o_push),
        .i_pop        (o_pop),
        .i_count      (r_count),
        .i_obuf_wr    (w_obuf_wr),
        .i_obuf_rd    (w_out_hs),
        .i_obuf_count (w_obuf_count)
    );

endmodule
